// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: FSM encoding, default SRAM timing and data-memory base shared by the memory stage.
package mem_stage_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_LO, ST_HI, ST_DONE} state_t;
   localparam int          SRAM_WAIT_DEF = 2;
   localparam logic [31:0] MEM_BASE_DEF  = 32'd1024;
   // Word index relative to the data-memory base, truncated to the 17 bits the SRAM can address.
   function automatic logic [16:0] word_index(input logic [31:0] addr, input logic [31:0] base);
      logic [31:0] w_off;
      w_off = addr - base;
      return w_off[18:2];
   endfunction
endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: pipeline-side and SRAM-side signals of the memory stage.
interface mem_stage_if;
   logic        wb_en_in;
   logic        mem_read_in;
   logic        mem_write_in;
   logic [31:0] alu_result;
   logic [31:0] val_Rm;
   logic [3:0]  dest_in;
   logic [31:0] result_wb;
   logic [3:0]  dest_wb;
   logic        write_back;
   logic        freeze;
   logic [17:0] sram_addr;
   logic [15:0] sram_wdata;
   logic [15:0] sram_rdata;
   logic        sram_we_n;
   modport slave (
      input  wb_en_in, mem_read_in, mem_write_in, alu_result, val_Rm, dest_in, sram_rdata,
      output result_wb, dest_wb, write_back, freeze, sram_addr, sram_wdata, sram_we_n
   );
   modport master (
      output wb_en_in, mem_read_in, mem_write_in, alu_result, val_Rm, dest_in, sram_rdata,
      input  result_wb, dest_wb, write_back, freeze, sram_addr, sram_wdata, sram_we_n
   );
endinterface

// File: rtl/mem_stage_sram_controller.sv
// sram_controller: splits a 32-bit access into two 16-bit SRAM halves and stalls the pipeline meanwhile.
module sram_controller import mem_stage_pkg::*; #(
   parameter int          SRAM_WAIT = SRAM_WAIT_DEF,
   parameter logic [31:0] MEM_BASE  = MEM_BASE_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_rd,
   input  logic        i_wr,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   input  logic [15:0] i_sram_rdata,
   output logic        o_freeze,
   output logic [17:0] o_sram_addr,
   output logic [15:0] o_sram_wdata,
   output logic        o_sram_we_n,
   output logic [31:0] o_rbuf
);
   localparam int CW = $clog2(SRAM_WAIT + 1);
   state_t        r_state, w_next;
   logic [CW-1:0] r_cnt;
   logic [31:0]   r_rbuf;
   logic          w_act, w_hi, w_last, w_load, w_drive;
   assign w_act   = (r_state == ST_LO) || (r_state == ST_HI);
   assign w_hi    = r_state == ST_HI;
   assign w_last  = r_cnt == CW'(SRAM_WAIT - 1);
   // A simultaneous read and write behaves as a write, so only pure loads fill the buffer.
   assign w_load  = i_rd && !i_wr;
   assign w_drive = w_act && i_wr;
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: w_next = (i_rd || i_wr) ? ST_LO : ST_IDLE;
         ST_LO:   w_next = w_last ? ST_HI : ST_LO;
         ST_HI:   w_next = w_last ? ST_DONE : ST_HI;
         default: w_next = ST_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_rbuf  <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= (w_act && !w_last) ? r_cnt + 1'b1 : '0;
         if (w_load && w_act && w_last) begin
            if (w_hi) r_rbuf[31:16] <= i_sram_rdata;
            else r_rbuf[15:0] <= i_sram_rdata;
         end
      end
   end
   assign o_freeze     = (i_rd || i_wr) && (r_state != ST_DONE);
   assign o_sram_addr  = w_act ? {word_index(i_addr, MEM_BASE), w_hi} : '0;
   assign o_sram_we_n  = !w_drive;
   assign o_sram_wdata = w_drive ? (w_hi ? i_wdata[31:16] : i_wdata[15:0]) : '0;
   assign o_rbuf       = r_rbuf;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage; SRAM sequencing in sram_controller, writeback register here.
module mem_stage import mem_stage_pkg::*; #(
   parameter int          SRAM_WAIT = SRAM_WAIT_DEF,
   parameter logic [31:0] MEM_BASE  = MEM_BASE_DEF
) (
   input logic        clk,
   input logic        rst,
   mem_stage_if.slave io_mem
);
   logic        w_freeze;
   logic [31:0] w_rbuf;
   logic [31:0] r_result;
   logic [3:0]  r_dest;
   logic        r_wb;
   sram_controller #(.SRAM_WAIT(SRAM_WAIT), .MEM_BASE(MEM_BASE)) u_ctrl (
      .clk          (clk),
      .rst          (rst),
      .i_rd         (io_mem.mem_read_in),
      .i_wr         (io_mem.mem_write_in),
      .i_addr       (io_mem.alu_result),
      .i_wdata      (io_mem.val_Rm),
      .i_sram_rdata (io_mem.sram_rdata),
      .o_freeze     (w_freeze),
      .o_sram_addr  (io_mem.sram_addr),
      .o_sram_wdata (io_mem.sram_wdata),
      .o_sram_we_n  (io_mem.sram_we_n),
      .o_rbuf       (w_rbuf)
   );
   // A stalled edge emits a bubble but keeps the last value and index visible.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_result <= '0;
         r_dest   <= '0;
         r_wb     <= 1'b0;
      end else if (!w_freeze) begin
         r_wb     <= io_mem.wb_en_in;
         r_dest   <= io_mem.dest_in;
         r_result <= (io_mem.mem_read_in && !io_mem.mem_write_in) ? w_rbuf : io_mem.alu_result;
      end else begin
         r_wb <= 1'b0;
      end
   end
   assign io_mem.freeze     = w_freeze;
   assign io_mem.result_wb  = r_result;
   assign io_mem.dest_wb    = r_dest;
   assign io_mem.write_back = r_wb;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: vector table, directed corner sequences and random ops against a word-level memory model.
module tb_mem_stage;
   import mem_stage_pkg::*;
   typedef struct {
      logic        wb;
      logic [31:0] alu;
      logic [3:0]  dest;
      logic [31:0] e_res;
      logic [3:0]  e_dest;
      logic        e_wb;
   } vec_t;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pre = 1'b1;
   logic        sel = 1'b0;
   logic        d_wb, d_rd, d_wr;
   logic [31:0] d_alu, d_rm;
   logic [3:0]  d_dest;
   logic [15:0] sram [0:4095];
   logic [31:0] mdl [0:2047];
   logic [33:0] wlog [$];
   logic [33:0] str_exp [4];
   vec_t        tv [4];
   int          checks = 0;
   int          errors = 0;
   int          frz, t;
   logic [31:0] res, ra;
   logic        w_frz, w_wb, w_wen;
   logic [31:0] w_res;
   logic [3:0]  w_dest;
   logic [17:0] w_addr;
   logic [15:0] w_wd;
   always #5 clk = ~clk;
   mem_stage_if m2 ();
   mem_stage_if m1 ();
   mem_stage u2 (.clk(clk), .rst(rst), .io_mem(m2));
   mem_stage #(.SRAM_WAIT(1)) u1 (.clk(clk), .rst(rst), .io_mem(m1));
   assign m2.wb_en_in     = !sel && d_wb;
   assign m2.mem_read_in  = !sel && d_rd;
   assign m2.mem_write_in = !sel && d_wr;
   assign m2.alu_result   = d_alu;
   assign m2.val_Rm       = d_rm;
   assign m2.dest_in      = d_dest;
   assign m2.sram_rdata   = sram[m2.sram_addr[11:0]];
   assign m1.wb_en_in     = sel && d_wb;
   assign m1.mem_read_in  = sel && d_rd;
   assign m1.mem_write_in = sel && d_wr;
   assign m1.alu_result   = d_alu;
   assign m1.val_Rm       = d_rm;
   assign m1.dest_in      = d_dest;
   assign m1.sram_rdata   = sram[m1.sram_addr[11:0]];
   assign w_frz  = sel ? m1.freeze : m2.freeze;
   assign w_wb   = sel ? m1.write_back : m2.write_back;
   assign w_wen  = sel ? m1.sram_we_n : m2.sram_we_n;
   assign w_res  = sel ? m1.result_wb : m2.result_wb;
   assign w_dest = sel ? m1.dest_wb : m2.dest_wb;
   assign w_addr = sel ? m1.sram_addr : m2.sram_addr;
   assign w_wd   = sel ? m1.sram_wdata : m2.sram_wdata;
   // SRAM behavioural model shared by both DUTs; preloaded while pre is high.
   always @(posedge clk) begin
      if (pre) begin
         for (int i = 0; i < 4096; i++) sram[i] <= 16'h0;
         sram[0]  <= 16'h1234;
         sram[1]  <= 16'hABCD;
         sram[10] <= 16'h5678;
         sram[11] <= 16'h9ABC;
      end else begin
         if (!m2.sram_we_n) sram[m2.sram_addr[11:0]] <= m2.sram_wdata;
         if (!m1.sram_we_n) sram[m1.sram_addr[11:0]] <= m1.sram_wdata;
      end
   end
   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask
   // Runs one op from posedge+1 to posedge+1 after its writeback edge, checking against the word model.
   task automatic do_op(input logic rd, input logic wr, input logic wb, input logic [31:0] alu,
                        input logic [31:0] rm, input logic [3:0] dest, input string nm,
                        output int o_frz, output logic [31:0] o_res);
      int          w, n, bad, ph;
      logic [31:0] off, exp_res;
      logic [16:0] idx;
      logic [17:0] ea;
      logic        en;
      logic [15:0] ed;
      w = sel ? 1 : 2;
      off = alu - 32'd1024;
      idx = off[18:2];
      exp_res = (rd && !wr) ? mdl[idx[10:0]] : alu;
      n = 0;
      bad = 0;
      wlog.delete();
      d_rd = rd; d_wr = wr; d_wb = wb; d_alu = alu; d_rm = rm; d_dest = dest;
      forever begin
         @(negedge clk);
         ph = (!(rd || wr) || n == 0 || n > 2 * w) ? 0 : (n <= w ? 1 : 2);
         ea = (ph == 0) ? 18'd0 : {idx, ph == 2};
         en = wr && ph != 0;
         ed = !en ? 16'd0 : (ph == 2 ? rm[31:16] : rm[15:0]);
         if (w_addr !== ea || w_wen !== !en || w_wd !== ed) bad++;
         if (!w_wen) wlog.push_back({w_addr, w_wd});
         if (w_frz !== 1'b1 || n > 40) break;
         n++;
      end
      @(posedge clk);
      #1;
      o_frz = n;
      o_res = w_res;
      chk({nm, " freeze cycles"}, n, (rd || wr) ? 1 + 2 * w : 0);
      chk({nm, " sram drive"}, bad, 0);
      chk({nm, " result_wb"}, w_res, exp_res);
      chk({nm, " dest_wb"}, w_dest, dest);
      chk({nm, " write_back"}, w_wb, wb);
      if (wr) mdl[idx[10:0]] = rm;
      d_rd = 0; d_wr = 0; d_wb = 0;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      for (int i = 0; i < 2048; i++) mdl[i] = 32'h0;
      mdl[0] = 32'hABCD1234;
      mdl[5] = 32'h9ABC5678;
      tv[0] = '{1'b1, 32'h00000007, 4'd3, 32'h00000007, 4'd3, 1'b1};
      tv[1] = '{1'b0, 32'hFFFFFFFF, 4'd15, 32'hFFFFFFFF, 4'd15, 1'b0};
      tv[2] = '{1'b1, 32'h00000400, 4'd0, 32'h00000400, 4'd0, 1'b1};
      tv[3] = '{1'b1, 32'h12345678, 4'd9, 32'h12345678, 4'd9, 1'b1};
      str_exp[0] = {18'd2, 16'hBEEF};
      str_exp[1] = {18'd2, 16'hBEEF};
      str_exp[2] = {18'd3, 16'hDEAD};
      str_exp[3] = {18'd3, 16'hDEAD};
      d_wb = 0; d_rd = 0; d_wr = 0; d_alu = 0; d_rm = 0; d_dest = 0;
      repeat (3) @(posedge clk);
      #1;
      rst = 0;
      pre = 0;
      @(negedge clk);
      chk("reset result_wb", w_res, 0);
      chk("reset dest_wb", w_dest, 0);
      chk("reset write_back", w_wb, 0);
      chk("reset freeze", w_frz, 0);
      chk("reset we_n", w_wen, 1);
      chk("reset sram_addr", w_addr, 0);
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         do_op(1'b0, 1'b0, tv[i].wb, tv[i].alu, 32'h0, tv[i].dest, "alu", frz, res);
         chk("alu tbl result", w_res, tv[i].e_res);
         chk("alu tbl dest", w_dest, tv[i].e_dest);
         chk("alu tbl wb", w_wb, tv[i].e_wb);
         chk("alu tbl freeze", frz, 0);
      end
      do_op(1'b0, 1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 4'd2, "str", frz, res);
      chk("str freeze", frz, 5);
      chk("str we_n cycles", wlog.size(), 4);
      for (int i = 0; i < 4; i++) chk("str sram cycle", (i < wlog.size()) ? wlog[i] : 34'h0, str_exp[i]);
      chk("str write_back", w_wb, 0);
      do_op(1'b1, 1'b0, 1'b1, 32'd1024, 32'h0, 4'd5, "ldr", frz, res);
      chk("ldr result", res, 32'hABCD1234);
      chk("ldr dest", w_dest, 5);
      chk("ldr freeze", frz, 5);
      @(posedge clk);
      #1;
      chk("ldr wb pulse end", w_wb, 0);
      do_op(1'b1, 1'b0, 1'b1, 32'd1028, 32'h0, 4'd4, "b2b ldr", frz, res);
      chk("b2b ldr result", res, 32'hDEADBEEF);
      do_op(1'b0, 1'b1, 1'b0, 32'd1032, 32'hCAFEF00D, 4'd0, "b2b str", frz, res);
      chk("b2b str freeze", frz, 5);
      do_op(1'b0, 1'b1, 1'b0, 32'd0, 32'h55AA33CC, 4'd0, "wrap str", frz, res);
      chk("wrap sram_addr", (wlog.size() > 0) ? wlog[0][33:16] : 18'h0, 18'h3FE00);
      do_op(1'b1, 1'b0, 1'b1, 32'd3, 32'h0, 4'd1, "wrap ldr", frz, res);
      chk("wrap ldr result", res, 32'h55AA33CC);
      do_op(1'b1, 1'b1, 1'b1, 32'd1036, 32'h0BADF00D, 4'd7, "rd+wr", frz, res);
      chk("rd+wr result", res, 32'd1036);
      do_op(1'b1, 1'b0, 1'b1, 32'd1036, 32'h0, 4'd8, "rd+wr readback", frz, res);
      chk("rd+wr stored", res, 32'h0BADF00D);
      d_wr = 1; d_wb = 1; d_alu = 32'd1424; d_rm = 32'h11112222; d_dest = 4'd6;
      repeat (4) @(negedge clk);
      chk("rst hi we_n", w_wen, 0);
      chk("rst hi addr", w_addr, {17'd100, 1'b1});
      rst = 1;
      @(posedge clk);
      #1;
      rst = 0;
      @(negedge clk);
      chk("rst abort we_n", w_wen, 1);
      chk("rst abort addr", w_addr, 0);
      chk("rst abort write_back", w_wb, 0);
      chk("rst abort result", w_res, 0);
      chk("rst abort freeze", w_frz, 1);
      d_wr = 0; d_wb = 0;
      @(posedge clk);
      #1;
      chk("rst after freeze", w_frz, 0);
      chk("rst after write_back", w_wb, 0);
      sel = 1;
      do_op(1'b1, 1'b0, 1'b1, 32'd1044, 32'h0, 4'd9, "w1 ldr", frz, res);
      chk("w1 freeze", frz, 3);
      chk("w1 result", res, 32'h9ABC5678);
      for (int k = 0; k < 60; k++) begin
         t = $urandom_range(0, 3);
         if ($urandom_range(0, 3) == 0) sel = ~sel;
         ra = (t == 0) ? $urandom : 32'd1024 + 4 * $urandom_range(0, 63) + $urandom_range(0, 3);
         do_op(t == 1 || t == 3, t == 2 || t == 3, 1'($urandom), ra, $urandom, 4'($urandom), "rand", frz, res);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
